// File: rtl/spi_avalon_bridge_fsm.sv
// SPI-slave to Avalon-MM transaction engine.
// Decodes a 32-bit header, then streams read or write bursts.
module spi_avalon_bridge_fsm #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 30,
  parameter int CNT_WIDTH   = 7,
  parameter int SWAP_BYTES  = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    csn,
  input  logic [CNT_WIDTH-1:0]    bit_cnt,
  input  logic [(DATA_WIDTH>32?DATA_WIDTH:32)-1:0] data_from_spi,
  input  logic                    ack,
  input  logic [DATA_WIDTH-1:0]   read_data_from_avalon,
  output logic                    read,
  output logic                    write,
  output logic [DATA_WIDTH/8-1:0] byte_enable,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   write_data_to_avalon,
  output logic [DATA_WIDTH-1:0]   read_data_to_spi,
  output logic [15:0]             word_count,
  output logic                    error,
  output logic                    busy
);

  localparam int SW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam int BW = DATA_WIDTH / 8;

  localparam logic [CNT_WIDTH-1:0] HDR_CNT  = CNT_WIDTH'(32);
  localparam logic [CNT_WIDTH-1:0] WORD_CNT = CNT_WIDTH'(32 + DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(BW);
  localparam logic [15:0] TMO_LAST          = 16'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_SPI  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_WR_REQ  = 3'd5;

  logic [2:0]           state;
  logic                 ack_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_qq;
  logic [SW-1:0]        data_q;
  logic                 hdr_evt;
  logic                 word_evt;
  logic                 fix;
  logic                 abort;
  logic [15:0]          tcnt;

  logic                  tmo;
  logic                  done;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [15:0]           wc_inc;
  logic [DATA_WIDTH-1:0] wdata_sw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q    <= 1'b0;
      cnt_q    <= '0;
      cnt_qq   <= '0;
      data_q   <= '0;
      hdr_evt  <= 1'b0;
      word_evt <= 1'b0;
    end else begin
      ack_q    <= ack;
      cnt_q    <= bit_cnt;
      cnt_qq   <= cnt_q;
      data_q   <= data_from_spi;
      hdr_evt  <= (cnt_q == HDR_CNT) && (cnt_qq != HDR_CNT);
      word_evt <= (cnt_q == WORD_CNT) && (cnt_qq != WORD_CNT);
    end
  end

  // ack in the same cycle as the timeout wins
  assign tmo  = (ACK_TIMEOUT != 0) && (tcnt == TMO_LAST);
  assign done = ack_q || tmo;

  assign addr_inc = fix ? address : address + STEP;
  assign wc_inc   = (&word_count) ? word_count : word_count + 16'd1;

  always_comb begin
    wdata_sw = data_q[DATA_WIDTH-1:0];
    if (SWAP_BYTES != 0) begin
      for (int i = 0; i < BW; i++) begin
        wdata_sw[8*i +: 8] = data_q[8*(BW-1-i) +: 8];
      end
    end
  end

  assign byte_enable = (read || write) ? '1 : '0;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      read                 <= 1'b0;
      write                <= 1'b0;
      address              <= '0;
      write_data_to_avalon <= '0;
      read_data_to_spi     <= '0;
      word_count           <= '0;
      error                <= 1'b0;
      fix                  <= 1'b0;
      abort                <= 1'b0;
      tcnt                 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!csn) state <= S_HDR;
        end
        S_HDR: begin
          if (csn) begin
            state <= S_IDLE;
          end else if (hdr_evt) begin
            address    <= data_q[ADDR_WIDTH-1:0];
            fix        <= data_q[30];
            error      <= 1'b0;
            word_count <= '0;
            tcnt       <= '0;
            abort      <= 1'b0;
            if (data_q[31]) begin
              read  <= 1'b1;
              state <= S_RD_REQ;
            end else begin
              state <= S_WR_WAIT;
            end
          end
        end
        S_RD_REQ: begin
          if (done) begin
            read             <= 1'b0;
            tcnt             <= '0;
            abort            <= 1'b0;
            read_data_to_spi <= ack_q ? read_data_from_avalon : '1;
            if (!ack_q) error <= 1'b1;
            state <= (abort || csn) ? S_IDLE : S_RD_SPI;
          end else begin
            tcnt <= tcnt + 16'd1;
            if (csn) abort <= 1'b1;
          end
        end
        S_RD_SPI: begin
          if (csn) begin
            state <= S_IDLE;
          end else if (word_evt) begin
            word_count <= wc_inc;
            address    <= addr_inc;
            tcnt       <= '0;
            read       <= 1'b1;
            state      <= S_RD_REQ;
          end
        end
        S_WR_WAIT: begin
          if (csn) begin
            state <= S_IDLE;
          end else if (word_evt) begin
            write_data_to_avalon <= wdata_sw;
            tcnt                 <= '0;
            write                <= 1'b1;
            state                <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (done) begin
            write <= 1'b0;
            tcnt  <= '0;
            abort <= 1'b0;
            if (!ack_q) error <= 1'b1;
            // an access cut short by csn is not counted
            if (!abort) begin
              word_count <= wc_inc;
              address    <= addr_inc;
            end
            state <= (abort || csn) ? S_IDLE : S_WR_WAIT;
          end else begin
            tcnt <= tcnt + 16'd1;
            if (csn) abort <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          read  <= 1'b0;
          write <= 1'b0;
          abort <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_avalon_bridge_fsm.sv
// Directed bench for spi_avalon_bridge_fsm.
// Instance a: 32-bit data, swap on, timeout 8. Instance b: 16-bit data, 8-bit address.
module tb_spi_avalon_bridge_fsm;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int pass  = 0;

  logic        a_csn = 1'b1;
  logic [6:0]  a_cnt = '0;
  logic [31:0] a_data = '0;
  logic        a_ack = 1'b0;
  logic [31:0] a_rdata = '0;
  logic        a_read, a_write, a_err, a_busy;
  logic [3:0]  a_be;
  logic [29:0] a_addr;
  logic [31:0] a_wdata, a_rdts;
  logic [15:0] a_wc;

  logic        b_csn = 1'b1;
  logic [6:0]  b_cnt = '0;
  logic [31:0] b_data = '0;
  logic        b_ack = 1'b0;
  logic [15:0] b_rdata = '0;
  logic        b_read, b_write, b_err, b_busy;
  logic [1:0]  b_be;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata, b_rdts;
  logic [15:0] b_wc;

  spi_avalon_bridge_fsm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(30), .CNT_WIDTH(7),
    .SWAP_BYTES(1), .ACK_TIMEOUT(8)
  ) dut_a (
    .clock(clock), .reset(reset), .csn(a_csn),
    .bit_cnt(a_cnt), .data_from_spi(a_data), .ack(a_ack),
    .read_data_from_avalon(a_rdata),
    .read(a_read), .write(a_write), .byte_enable(a_be),
    .address(a_addr), .write_data_to_avalon(a_wdata),
    .read_data_to_spi(a_rdts), .word_count(a_wc),
    .error(a_err), .busy(a_busy)
  );

  spi_avalon_bridge_fsm #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .CNT_WIDTH(7),
    .SWAP_BYTES(1), .ACK_TIMEOUT(8)
  ) dut_b (
    .clock(clock), .reset(reset), .csn(b_csn),
    .bit_cnt(b_cnt), .data_from_spi(b_data), .ack(b_ack),
    .read_data_from_avalon(b_rdata),
    .read(b_read), .write(b_write), .byte_enable(b_be),
    .address(b_addr), .write_data_to_avalon(b_wdata),
    .read_data_to_spi(b_rdts), .word_count(b_wc),
    .error(b_err), .busy(b_busy)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic a_start(input logic [31:0] hdr);
    a_csn = 1'b0;
    a_cnt = 7'd0;
    cyc(2);
    a_data = hdr;
    a_cnt  = 7'd32;
  endtask

  task automatic a_word(input logic [31:0] d);
    a_data = d;
    a_cnt  = 7'd64;
  endtask

  task automatic a_reload();
    a_cnt = 7'd32;
    cyc(1);
  endtask

  task automatic a_pulse(input logic [31:0] v);
    a_rdata = v;
    a_ack   = 1'b1;
    cyc(1);
    a_ack = 1'b0;
    cyc(1);
  endtask

  task automatic a_end();
    a_csn = 1'b1;
    a_cnt = 7'd0;
    cyc(2);
  endtask

  task automatic test_reset();
    cyc(1);
    total++;
    if ({a_read, a_write, a_be, a_addr, a_wdata, a_rdts, a_wc, a_err, a_busy} !== '0)
      $display("FAIL reset_a: outputs not all zero (addr=%h wc=%h busy=%b)", a_addr, a_wc, a_busy);
    else pass++;
    total++;
    if ({b_read, b_write, b_be, b_addr, b_wdata, b_rdts, b_wc, b_err, b_busy} !== '0)
      $display("FAIL reset_b: outputs not all zero (addr=%h wc=%h busy=%b)", b_addr, b_wc, b_busy);
    else pass++;
    reset = 1'b0;
    cyc(2);
    total++;
    if (a_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", a_busy);
    else pass++;
  endtask

  task automatic test_single_read();
    a_start(32'h8000_0100);
    cyc(2);
    total++;
    if (a_read !== 1'b0) $display("FAIL rd_lat_early: read=%b want 0", a_read);
    else pass++;
    cyc(1);
    total++;
    if (a_read !== 1'b1) $display("FAIL rd_lat: read=%b want 1", a_read);
    else pass++;
    total++;
    if (a_addr !== 30'h100) $display("FAIL rd_addr: got %h want 100", a_addr);
    else pass++;
    total++;
    if (a_be !== 4'hF) $display("FAIL rd_be: got %h want f", a_be);
    else pass++;
    cyc(2);
    a_pulse(32'h1122_3344);
    total++;
    if (a_read !== 1'b0) $display("FAIL rd_drop: read=%b want 0", a_read);
    else pass++;
    total++;
    if (a_rdts !== 32'h1122_3344) $display("FAIL rd_data: got %h want 11223344", a_rdts);
    else pass++;
    total++;
    if (a_wc !== 16'd0) $display("FAIL rd_wc0: got %0d want 0", a_wc);
    else pass++;
    a_word(32'h0);
    cyc(3);
    total++;
    if (a_wc !== 16'd1) $display("FAIL rd_wc1: got %0d want 1", a_wc);
    else pass++;
    total++;
    if ({a_read, a_addr} !== {1'b1, 30'h104}) $display("FAIL rd_prefetch: read=%b addr=%h want 1/104", a_read, a_addr);
    else pass++;
    a_pulse(32'h5566_7788);
    a_reload();
    a_end();
    total++;
    if (a_busy !== 1'b0) $display("FAIL rd_end_busy: got %b want 0", a_busy);
    else pass++;
  endtask

  task automatic test_write_burst();
    a_start(32'h0000_0200);
    cyc(3);
    total++;
    if ({a_busy, a_write} !== 2'b10) $display("FAIL wr_wait: busy/write=%b want 10", {a_busy, a_write});
    else pass++;
    a_word(32'hAABB_CCDD);
    cyc(2);
    total++;
    if (a_write !== 1'b0) $display("FAIL wr_lat_early: write=%b want 0", a_write);
    else pass++;
    cyc(1);
    total++;
    if ({a_write, a_addr, a_wdata} !== {1'b1, 30'h200, 32'hDDCC_BBAA})
      $display("FAIL wr_word0: write=%b addr=%h data=%h want 1/200/ddccbbaa", a_write, a_addr, a_wdata);
    else pass++;
    a_pulse(32'h0);
    total++;
    if ({a_write, a_wc} !== {1'b0, 16'd1}) $display("FAIL wr_ack0: write=%b wc=%0d want 0/1", a_write, a_wc);
    else pass++;
    a_reload();
    a_word(32'h0102_0304);
    cyc(3);
    total++;
    if ({a_write, a_addr, a_wdata} !== {1'b1, 30'h204, 32'h0403_0201})
      $display("FAIL wr_word1: write=%b addr=%h data=%h want 1/204/04030201", a_write, a_addr, a_wdata);
    else pass++;
    a_pulse(32'h0);
    total++;
    if ({a_wc, a_addr} !== {16'd2, 30'h208}) $display("FAIL wr_ack1: wc=%0d addr=%h want 2/208", a_wc, a_addr);
    else pass++;
    a_reload();
    a_end();
  endtask

  task automatic test_fix_mode();
    a_start(32'h4000_0040);
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      a_word(32'h1111_1111 * (k + 1));
      cyc(3);
      total++;
      if ({a_write, a_addr} !== {1'b1, 30'h40}) $display("FAIL fix_addr%0d: write=%b addr=%h want 1/40", k, a_write, a_addr);
      else pass++;
      a_pulse(32'h0);
      a_reload();
    end
    total++;
    if ({a_wc, a_addr} !== {16'd3, 30'h40}) $display("FAIL fix_wc: wc=%0d addr=%h want 3/40", a_wc, a_addr);
    else pass++;
    a_end();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    a_start(32'h8000_0010);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (a_read) n++;
    end
    total++;
    if (n !== 8) $display("FAIL tmo_cycles: read high %0d cycles want 8", n);
    else pass++;
    total++;
    if ({a_read, a_err} !== 2'b01) $display("FAIL tmo_err: read=%b error=%b want 0/1", a_read, a_err);
    else pass++;
    total++;
    if (a_rdts !== 32'hFFFF_FFFF) $display("FAIL tmo_data: got %h want ffffffff", a_rdts);
    else pass++;
    a_end();
    total++;
    if ({a_busy, a_err} !== 2'b01) $display("FAIL tmo_sticky: busy=%b error=%b want 0/1", a_busy, a_err);
    else pass++;
    a_start(32'h0000_0000);
    cyc(3);
    total++;
    if (a_err !== 1'b0) $display("FAIL tmo_clear: error=%b want 0", a_err);
    else pass++;
    a_end();
  endtask

  task automatic test_abort();
    int held;
    held = 0;
    a_start(32'h0000_0300);
    cyc(3);
    a_word(32'h1234_5678);
    cyc(3);
    total++;
    if (a_write !== 1'b1) $display("FAIL ab_write: write=%b want 1", a_write);
    else pass++;
    a_csn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (a_write) held++;
    end
    total++;
    if (held !== 5) $display("FAIL ab_hold: write held %0d cycles want 5", held);
    else pass++;
    a_pulse(32'h0);
    total++;
    if ({a_write, a_busy, a_err} !== 3'b000) $display("FAIL ab_idle: write/busy/err=%b want 000", {a_write, a_busy, a_err});
    else pass++;
    total++;
    if ({a_addr, a_wc} !== {30'h300, 16'd0}) $display("FAIL ab_addr: addr=%h wc=%0d want 300/0", a_addr, a_wc);
    else pass++;
    a_cnt = 7'd0;
    cyc(2);
  endtask

  task automatic test_narrow_wrap();
    b_csn = 1'b0;
    b_cnt = 7'd0;
    cyc(2);
    b_data = 32'h8000_00FE;
    b_cnt  = 7'd32;
    cyc(3);
    total++;
    if ({b_read, b_addr, b_be} !== {1'b1, 8'hFE, 2'b11}) $display("FAIL nw_rd0: read=%b addr=%h be=%b want 1/fe/11", b_read, b_addr, b_be);
    else pass++;
    b_rdata = 16'hBEEF;
    b_ack = 1'b1;
    cyc(1);
    b_ack = 1'b0;
    cyc(1);
    total++;
    if ({b_read, b_rdts} !== {1'b0, 16'hBEEF}) $display("FAIL nw_data0: read=%b data=%h want 0/beef", b_read, b_rdts);
    else pass++;
    b_cnt = 7'd48;
    cyc(3);
    total++;
    if ({b_read, b_addr, b_be, b_wc} !== {1'b1, 8'h00, 2'b11, 16'd1})
      $display("FAIL nw_rd1: read=%b addr=%h be=%b wc=%0d want 1/00/11/1", b_read, b_addr, b_be, b_wc);
    else pass++;
    b_rdata = 16'hCAFE;
    b_ack = 1'b1;
    cyc(1);
    b_ack = 1'b0;
    cyc(1);
    total++;
    if (b_rdts !== 16'hCAFE) $display("FAIL nw_data1: got %h want cafe", b_rdts);
    else pass++;
    b_cnt = 7'd32;
    cyc(1);
    b_cnt = 7'd48;
    cyc(3);
    total++;
    if ({b_wc, b_addr} !== {16'd2, 8'h02}) $display("FAIL nw_wc: wc=%0d addr=%h want 2/02", b_wc, b_addr);
    else pass++;
    b_rdata = 16'h0;
    b_ack = 1'b1;
    cyc(1);
    b_ack = 1'b0;
    b_csn = 1'b1;
    cyc(3);
    total++;
    if ({b_read, b_busy} !== 2'b00) $display("FAIL nw_end: read/busy=%b want 00", {b_read, b_busy});
    else pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_fix_mode();
    test_timeout();
    test_abort();
    test_narrow_wrap();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
